mem_byte_sequencer: RTL and testbench



---
 rtl/mem_byte_sequencer.sv | 126 ++++++++++++
 tb/tb_mem_byte_sequencer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_byte_sequencer.sv
// Sequences LB/LW/SB/SW accesses into big-endian byte transfers on a byte-wide
// data memory, stalling the pipeline and returning the sign-extended load value.
module mem_byte_sequencer #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              is_mem_inst,
  input  logic              is_word,
  input  logic              mem_write_en,
  input  logic [31:0]       addr,
  input  logic [31:0]       store_data,
  output logic              stall,
  output logic              done,
  output logic              misaligned,
  output logic [31:0]       load_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ack
);

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    FIN
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [1:0]  byte_idx;
  logic        word_q;
  logic        we_q;
  logic [23:0] sd_q;
  logic [23:0] asm_q;
  logic        accept;
  logic        mis_acc;
  logic        last_byte;

  assign accept    = (state == IDLE) && start && is_mem_inst;
  assign mis_acc   = is_word && (addr[1:0] != 2'b00);
  assign last_byte = !word_q || (byte_idx == 2'd3);
  // Released in FIN so the pipeline advances on the completing edge.
  assign stall     = (state == XFER) || accept;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = mis_acc ? FIN : XFER;
      XFER:    if (mem_ack && last_byte) state_nx = FIN;
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_idx   <= '0;
      word_q     <= 1'b0;
      we_q       <= 1'b0;
      sd_q       <= '0;
      asm_q      <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      done       <= 1'b0;
      misaligned <= 1'b0;
      load_data  <= '0;
    end else begin
      done       <= 1'b0;
      misaligned <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            byte_idx <= '0;
            word_q   <= is_word;
            we_q     <= mem_write_en;
            asm_q    <= '0;
            if (mis_acc) begin
              misaligned <= 1'b1;
            end else begin
              mem_req   <= 1'b1;
              mem_we    <= mem_write_en;
              mem_addr  <= addr[ADDR_W-1:0];
              mem_wdata <= is_word ? store_data[31:24] : store_data[7:0];
              sd_q      <= store_data[23:0];
            end
          end
        end
        XFER: begin
          if (mem_ack) begin
            if (last_byte) begin
              mem_req <= 1'b0;
              mem_we  <= 1'b0;
              done    <= 1'b1;
              if (!we_q) begin
                load_data <= word_q ? {asm_q, mem_rdata} : {{24{mem_rdata[7]}}, mem_rdata};
              end
            end else begin
              // Remaining store bytes sit MSB-first in sd_q; next byte is always its top slice.
              byte_idx  <= byte_idx + 2'd1;
              mem_addr  <= mem_addr + ADDR_W'(1);
              mem_wdata <= sd_q[23:16];
              sd_q      <= {sd_q[15:0], 8'h00};
              asm_q     <= {asm_q[15:0], mem_rdata};
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_byte_sequencer.sv
// Randomized self-checking bench for mem_byte_sequencer with a byte-array memory
// responder and an access-level reference model.
module tb_mem_byte_sequencer;
  localparam int unsigned ADDR_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              is_mem_inst;
  logic              is_word;
  logic              mem_write_en;
  logic [31:0]       addr;
  logic [31:0]       store_data;
  logic              stall;
  logic              done;
  logic              misaligned;
  logic [31:0]       load_data;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;
  logic              mem_ack;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [7:0]  mem [1024];
  logic [31:0] model_load;

  always #5 clk = ~clk;

  mem_byte_sequencer #(.ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .is_mem_inst  (is_mem_inst),
    .is_word      (is_word),
    .mem_write_en (mem_write_en),
    .addr         (addr),
    .store_data   (store_data),
    .stall        (stall),
    .done         (done),
    .misaligned   (misaligned),
    .load_data    (load_data),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_ack      (mem_ack)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_req"}, {31'b0, mem_req}, 32'd0);
    check_eq({tag, "_we"}, {31'b0, mem_we}, 32'd0);
    check_eq({tag, "_addr"}, mem_addr, 32'd0);
    check_eq({tag, "_wdata"}, {24'b0, mem_wdata}, 32'd0);
    check_eq({tag, "_done"}, {31'b0, done}, 32'd0);
    check_eq({tag, "_mis"}, {31'b0, misaligned}, 32'd0);
    check_eq({tag, "_load"}, load_data, 32'd0);
  endtask

  // One complete access: predicts transfers, latency and load value from the
  // memory array, acts as the memory responder with per-byte wait states.
  task automatic run_op(input bit w, input bit we, input logic [31:0] a, input logic [31:0] sd,
                        input int unsigned minw, input int unsigned maxw, input bit spur);
    int unsigned n, idx, wl, cyc, exp_cyc, reqs, base;
    int unsigned wt [4];
    bit          mis, fin;
    logic [31:0] exp_ld;
    logic [7:0]  eb;
    mis     = w && (a[1:0] != 2'b00);
    n       = w ? 4 : 1;
    base    = int'(a[9:0]);
    exp_cyc = mis ? 1 : 1 + n;
    for (int i = 0; i < 4; i++) begin
      wt[i] = $urandom_range(maxw, minw);
      if (!mis && i < n) exp_cyc += wt[i];
    end
    exp_ld = model_load;
    if (!mis && !we)
      exp_ld = w ? {mem[base], mem[base+1], mem[base+2], mem[base+3]}
                 : {{24{mem[base][7]}}, mem[base]};

    @(posedge clk); #1;
    start = 1'b1; is_mem_inst = 1'b1; is_word = w; mem_write_en = we;
    addr = a; store_data = sd; mem_ack = 1'b0;
    #1 check_eq("stall_accept", {31'b0, stall}, 32'd1);

    fin = 1'b0; cyc = 0; reqs = 0; idx = 0; wl = wt[0];
    while (!fin && cyc < 64) begin
      @(posedge clk); #1;
      cyc++;
      mem_ack   = 1'b0;
      mem_rdata = 8'($urandom);
      start     = 1'b0;
      if (done || misaligned) begin
        fin = 1'b1;
        check_eq("done", {31'b0, done}, {31'b0, !mis});
        check_eq("misaligned", {31'b0, misaligned}, {31'b0, mis});
        check_eq("latency", cyc, exp_cyc);
        check_eq("req_count", reqs, mis ? 0 : n);
        check_eq("load_data", load_data, exp_ld);
        #1 check_eq("stall_fin", {31'b0, stall}, 32'd0);
      end else if (mem_req && idx < n) begin
        eb = w ? 8'(sd >> (8 * (3 - idx))) : sd[7:0];
        check_eq("mem_addr", mem_addr, a + idx);
        check_eq("mem_we", {31'b0, mem_we}, {31'b0, we});
        if (we) check_eq("mem_wdata", {24'b0, mem_wdata}, {24'b0, eb});
        if (spur) begin
          start = 1'($urandom); addr = $urandom; store_data = $urandom;
          is_word = 1'($urandom); mem_write_en = 1'($urandom);
        end
        if (wl > 0) begin
          wl--;
        end else begin
          mem_ack = 1'b1;
          if (we) mem[base+idx] = mem_wdata;
          else    mem_rdata = mem[base+idx];
          reqs++;
          idx++;
          if (idx < n) wl = wt[idx];
        end
        #1 check_eq("stall_xfer", {31'b0, stall}, 32'd1);
      end else begin
        check_eq("req_sequence", {31'b0, mem_req}, {31'b0, idx < n});
      end
    end
    if (!fin) check_eq("timeout", 32'd0, 32'd1);
    model_load = exp_ld;
    start = 1'b0; mem_ack = 1'b0;
  endtask

  task automatic idle_cycles(input int unsigned n, input bit spur_ack, input bit nonmem);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk); #1;
      check_eq("idle_req", {31'b0, mem_req}, 32'd0);
      check_eq("idle_done", {31'b0, done}, 32'd0);
      check_eq("idle_mis", {31'b0, misaligned}, 32'd0);
      check_eq("idle_load", load_data, model_load);
      start = nonmem; is_mem_inst = 1'b0; addr = $urandom;
      is_word = 1'($urandom); mem_write_en = 1'($urandom);
      mem_ack = spur_ack && (i + 1 < n);
      mem_rdata = 8'($urandom);
      #1 check_eq("idle_stall", {31'b0, stall}, 32'd0);
    end
    start = 1'b0; is_mem_inst = 1'b1; mem_ack = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; is_mem_inst = 1'b0; is_word = 1'b0; mem_write_en = 1'b0;
    addr = '0; store_data = '0; mem_rdata = '0; mem_ack = 1'b0;
    model_load = '0;
    for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
    mem[259] = 8'h80;
    mem[512] = 8'h12; mem[513] = 8'h34; mem[514] = 8'h56; mem[515] = 8'h78;

    #3 check_all_zero("reset");
    check_eq("reset_stall", {31'b0, stall}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    run_op(1'b0, 1'b0, 32'h103, 32'h0, 0, 0, 1'b0);
    check_eq("lb_sext", load_data, 32'hFFFFFF80);

    run_op(1'b1, 1'b0, 32'h200, 32'h0, 1, 1, 1'b0);
    check_eq("lw_value", load_data, 32'h12345678);

    run_op(1'b1, 1'b1, 32'h40, 32'hDEADBEEF, 0, 0, 1'b0);
    check_eq("sw_keep_load", load_data, 32'h12345678);
    check_eq("sw_mem0", {24'b0, mem[64]}, 32'hDE);
    check_eq("sw_mem1", {24'b0, mem[65]}, 32'hAD);
    check_eq("sw_mem2", {24'b0, mem[66]}, 32'hBE);
    check_eq("sw_mem3", {24'b0, mem[67]}, 32'hEF);

    run_op(1'b1, 1'b0, 32'h202, 32'h0, 0, 0, 1'b0);
    check_eq("mis_keep_load", load_data, 32'h12345678);
    idle_cycles(3, 1'b0, 1'b1);

    // Reset after the second byte ack of a word store.
    @(posedge clk); #1;
    start = 1'b1; is_mem_inst = 1'b1; is_word = 1'b1; mem_write_en = 1'b1;
    addr = 32'h80; store_data = 32'h11223344; mem_ack = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      check_eq("rst_pre_req", {31'b0, mem_req}, 32'd1);
      mem_ack = 1'b1;
    end
    @(posedge clk); #1;
    mem_ack = 1'b0;
    check_eq("rst_pre_addr", mem_addr, 32'h82);
    rst = 1'b1;
    #1 check_all_zero("rst_mid");
    model_load = '0;
    repeat (2) @(posedge clk);
    #1 check_eq("rst_hold_req", {31'b0, mem_req}, 32'd0);
    @(negedge clk) rst = 1'b0;
    idle_cycles(3, 1'b0, 1'b0);
    run_op(1'b0, 1'b0, 32'h103, 32'h0, 0, 1, 1'b0);
    check_eq("lb_after_rst", load_data, 32'hFFFFFF80);

    run_op(1'b0, 1'b1, 32'h10, 32'hAAAAAA7F, 0, 0, 1'b0);
    run_op(1'b0, 1'b0, 32'h10, $urandom, 0, 2, 1'b1);
    check_eq("lb_b2b", load_data, 32'h0000007F);
    idle_cycles(4, 1'b1, 1'b0);

    for (int k = 0; k < 150; k++) begin
      bit          w, we;
      logic [31:0] a;
      w  = 1'($urandom);
      we = 1'($urandom);
      a  = 32'($urandom_range(1019, 0));
      if (w && $urandom_range(3, 0) != 0) a[1:0] = 2'b00;
      run_op(w, we, a, $urandom, 0, 3, 1'($urandom));
      if ($urandom_range(3, 0) == 0)
        idle_cycles($urandom_range(3, 1), 1'($urandom), 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
